fir_out_collector: RTL and testbench
====================================

FIR_OUT_COLLECTOR -- requirements
Module: fir_out_collector

Interface
REQ-001 Parameter: pDATA_WIDTH, default 32, stream data width.
REQ-002 Parameter: pDEPTH, default 16, FIFO entries (power of 2, >=2).
REQ-003 Clock is axis_clk; one clock; reset is synchronous and active-high, port axis_rst.
REQ-004 axis_clk  in  1  sole clock, all state updates on rising edge.
REQ-005 axis_rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse; latches cfg_len and begins a frame.
REQ-007 cfg_len  in  32  expected beat count of frame (FIR data_length).
REQ-008 s_tvalid / s_tdata / s_tlast  in  1 / pDATA_WIDTH / 1  upstream FIR sm_* output stream.
REQ-009 s_tready  out  1  upstream ready (drives FIR sm_tready).
REQ-010 m_tvalid / m_tdata / m_tlast  out  1 / pDATA_WIDTH / 1  downstream stream.
REQ-011 m_tready  in  1  downstream ready.
REQ-012 beat_cnt  out  32  beats accepted in current frame.
REQ-013 level  out  log2(pDEPTH)+1  FIFO occupancy.
REQ-014 frame_done  out  1  one-cycle pulse at frame completion.
REQ-015 len_err  out  1  sticky length-mismatch flag.
REQ-016 clr_err  in  1  clears len_err.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; transfer on any port only when valid&&ready at rising edge.
REQ-018 IDLE: s_tready=0; start with cfg_len!=0 -> latch length, beat_cnt<=0, go RUN next cycle.
REQ-019 IDLE: start with cfg_len==0 -> set len_err, stay IDLE.
REQ-020 start outside IDLE ignored, no effect.
REQ-021 RUN: s_tready = !full (registered-state combinational, no full pass-through).
REQ-022 Accepted beat: push {s_tdata, last_tag}, beat_cnt+1; last_tag = s_tlast | (beat_cnt+1 == latched length).
REQ-023 Accepted beat with last_tag=1 -> go DRAIN; if s_tlast XOR (beat_cnt+1==length) then set len_err same edge.
REQ-024 DRAIN: s_tready=0; when FIFO empty -> frame_done=1 for exactly one cycle, go IDLE.
REQ-025 FIFO first-word fall-through: m_tvalid = !empty, m_tdata/m_tlast = head entry, combinational from registered storage.
REQ-026 Pop on m_tvalid&&m_tready; simultaneous push and pop keeps level unchanged, data order preserved.
REQ-027 Pointers wrap modulo pDEPTH; full = (level==pDEPTH), empty = (level==0).
REQ-028 m_tdata/m_tvalid held stable while m_tvalid&&!m_tready.
REQ-029 Data passed bit-exact, signed value unchanged, no arithmetic on payload.
REQ-030 Latency: beat accepted at edge N visible on m_* after edge N when FIFO was empty.
REQ-031 clr_err clears len_err; concurrent set event wins over clr_err.
REQ-032 beat_cnt holds final value in DRAIN/IDLE until next accepted start.

Reset
REQ-033 axis_rst: state IDLE, FIFO emptied, level=0, beat_cnt=0, len_err=0, frame_done=0, m_tvalid=0, s_tready=0.
REQ-034 Reset mid-frame discards all buffered data; no frame_done issued.
REQ-035 Reset has priority over start, clr_err and all handshakes.

Verification
REQ-036 start, cfg_len=600, 600 beats continuous, m_tready=1, tlast on beat 600 -> 600 beats out in order, m_tlast only on 600th, frame_done once, len_err=0.
REQ-037 cfg_len=20, m_tready=0 -> s_tready drops after 16 accepted, level=16; m_tready=1 -> all 20 out, order intact.
REQ-038 cfg_len=10, s_tlast on beat 7 -> m_tlast on beat 7, DRAIN, len_err=1, beat_cnt=7; clr_err -> len_err=0.
REQ-039 cfg_len=5, no s_tlast -> m_tlast forced on beat 5, len_err=1; cfg_len=0 start -> len_err=1, stays IDLE.
REQ-040 Random s_tvalid/m_tready toggling, 600 beats -> output equals input sequence, level never >16, no drop/duplicate.
REQ-041 axis_rst asserted at beat 300 of 600 -> next cycle m_tvalid=0, level=0, beat_cnt=0, no frame_done; fresh start works.

Source files
------------

// File: rtl/fir_out_collector.sv
// Output collector for the FIR stream: frames beats by a programmed length,
// buffers them in a first-word-fall-through FIFO and flags length mismatches.
module fir_out_collector #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  input  logic                     start,
  input  logic [31:0]              cfg_len,
  input  logic                     s_tvalid,
  input  logic [pDATA_WIDTH-1:0]   s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [pDATA_WIDTH-1:0]   m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [31:0]              beat_cnt,
  output logic [$clog2(pDEPTH):0]  level,
  output logic                     frame_done,
  output logic                     len_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(pDEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [pDATA_WIDTH:0]  mem_q [pDEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]           len_q, len_d;
  logic                  len_err_q, len_err_d;

  logic                  full, empty, push, pop;
  logic [31:0]           cnt_inc;
  logic                  len_hit, last_tag, len_set;

  always_comb begin
    full     = (level_q == LW'(pDEPTH));
    empty    = (level_q == '0);
    s_tready = (state_q == S_RUN) && !full;
    m_tvalid = !empty;
    m_tdata  = mem_q[rd_ptr_q][pDATA_WIDTH:1];
    m_tlast  = mem_q[rd_ptr_q][0];
    push     = s_tvalid && s_tready;
    pop      = m_tvalid && m_tready;
    cnt_inc  = beat_cnt_q + 32'd1;
    len_hit  = (cnt_inc == len_q);
    // The last tag closes the frame on whichever comes first: s_tlast or the count.
    last_tag = s_tlast || len_hit;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    frame_done = 1'b0;
    len_set    = 1'b0;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_len != 32'd0) begin
            state_d    = S_RUN;
            len_d      = cfg_len;
            beat_cnt_d = 32'd0;
          end else begin
            len_set = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (push) begin
          beat_cnt_d = cnt_inc;
          if (last_tag) begin
            state_d = S_DRAIN;
            len_set = s_tlast ^ len_hit;
          end
        end
      end
      S_DRAIN: begin
        if (empty) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    // A new error in the same cycle outranks a clear request.
    len_err_d = len_set ? 1'b1 : (clr_err ? 1'b0 : len_err_q);
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and level
  // is enough to make stale contents unreachable.
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_tdata, last_tag};
  end

  assign beat_cnt = beat_cnt_q;
  assign level    = level_q;
  assign len_err  = len_err_q;

endmodule

// File: tb/tb_fir_out_collector.sv
// Randomised bench for fir_out_collector, checked cycle by cycle against a
// queue-based model of the framing, buffering and error rules.
module tb_fir_out_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          axis_clk = 1'b0;
  logic          axis_rst, start, clr_err, s_tvalid, s_tlast, m_tready;
  logic [31:0]   cfg_len;
  logic [DW-1:0] s_tdata;
  logic          s_tready, m_tvalid, m_tlast, frame_done, len_err;
  logic [DW-1:0] m_tdata;
  logic [31:0]   beat_cnt;
  logic [4:0]    level;

  fir_out_collector #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .s_tvalid  (s_tvalid),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tready  (m_tready),
    .beat_cnt  (beat_cnt),
    .level     (level),
    .frame_done(frame_done),
    .len_err   (len_err),
    .clr_err   (clr_err)
  );

  always #5 axis_clk = ~axis_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of {data, last} in flight, frame flags and counters.
  logic [DW:0]  mq[$];
  bit           m_busy = 0, m_acc = 0, m_err = 0;
  int unsigned  m_len = 0, m_beat = 0;
  int           done_cnt = 0, tlast_cnt = 0, max_level = 0;
  bit           push_seen;

  // Called with inputs already set after a falling edge; checks, then advances one edge.
  task automatic cycle();
    bit exp_done, pop, set_e, tag;
    #1;
    exp_done = m_busy && !m_acc && (mq.size() == 0);
    check("s_tready",   s_tready,   m_acc && (mq.size() < DEPTH));
    check("level",      level,      mq.size());
    check("m_tvalid",   m_tvalid,   mq.size() != 0);
    if (mq.size() != 0) check("m_data", {m_tdata, m_tlast}, mq[0]);
    check("frame_done", frame_done, exp_done);
    check("beat_cnt",   beat_cnt,   m_beat);
    check("len_err",    len_err,    m_err);
    if (int'(level) > max_level) max_level = int'(level);
    push_seen = s_tvalid && s_tready;
    pop       = m_tvalid && m_tready;
    if (frame_done) done_cnt++;
    if (pop && m_tlast) tlast_cnt++;
    if (axis_rst) begin
      mq.delete();
      m_busy = 0; m_acc = 0; m_beat = 0; m_err = 0;
    end else begin
      set_e = 0;
      if (pop && mq.size() != 0) void'(mq.pop_front());
      if (!m_busy && start) begin
        if (cfg_len == 0) set_e = 1;
        else begin
          m_busy = 1; m_acc = 1; m_len = cfg_len; m_beat = 0;
        end
      end
      if (push_seen) begin
        m_beat++;
        tag = s_tlast || (m_beat == m_len);
        mq.push_back({s_tdata, tag});
        if (tag) begin
          m_acc = 0;
          if (s_tlast != (m_beat == m_len)) set_e = 1;
        end
      end
      if (exp_done) m_busy = 0;
      m_err = set_e ? 1'b1 : (clr_err ? 1'b0 : m_err);
    end
    @(posedge axis_clk);
    @(negedge axis_clk);
  endtask

  task automatic idle(input int n);
    start = 0; clr_err = 0; s_tvalid = 0; s_tlast = 0; m_tready = 1;
    repeat (n) cycle();
  endtask

  // One frame: len programmed, nbeats offered, s_tlast on beat tlast_at (0 = never).
  // stall holds m_tready low for that many cycles; rst_at / start_at / clr_at
  // inject a reset, a stray start, or a clear at the given beat.
  task automatic run_frame(input int len, input int nbeats, input int tlast_at,
                           input bit rnd, input int stall, input int rst_at,
                           input int start_at, input int clr_at);
    int sent = 0;
    int cyc  = 0;
    bit did_start = 0;
    start = 1; cfg_len = len; s_tvalid = 0; s_tlast = 0; m_tready = 1;
    cycle();
    start = 0;
    while ((sent < nbeats || m_busy) && cyc < 5000) begin
      s_tvalid = (sent < nbeats) && (!rnd || $urandom_range(0, 1) != 0);
      s_tdata  = $urandom;
      s_tlast  = (sent + 1 == tlast_at);
      m_tready = (cyc >= stall) && (!rnd || $urandom_range(0, 3) != 0);
      start    = (start_at > 0) && (sent == start_at) && !did_start;
      if (start) begin
        cfg_len   = 3;
        did_start = 1;
      end
      clr_err = (clr_at > 0) && (sent + 1 == clr_at);
      if (rst_at > 0 && sent == rst_at) begin
        axis_rst = 1;
        cycle();
        axis_rst = 0; start = 0; clr_err = 0; s_tvalid = 0; m_tready = 0;
        #1;
        check("rst_m_tvalid",   m_tvalid,   0);
        check("rst_level",      level,      0);
        check("rst_beat_cnt",   beat_cnt,   0);
        check("rst_frame_done", frame_done, 0);
        check("rst_s_tready",   s_tready,   0);
        @(negedge axis_clk);
        return;
      end
      cycle();
      if (push_seen) sent++;
      cyc++;
    end
    start = 0; clr_err = 0; s_tvalid = 0; s_tlast = 0;
    check("frame_timeout", cyc < 5000, 1);
  endtask

  int d0, t0;

  initial begin
    axis_rst = 1; start = 0; clr_err = 0; cfg_len = 0;
    s_tvalid = 0; s_tdata = 0; s_tlast = 0; m_tready = 0;
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    axis_rst = 0;
    check("reset_m_tvalid",   m_tvalid,   0);
    check("reset_s_tready",   s_tready,   0);
    check("reset_level",      level,      0);
    check("reset_beat_cnt",   beat_cnt,   0);
    check("reset_len_err",    len_err,    0);
    check("reset_frame_done", frame_done, 0);
    idle(2);

    // Long continuous frame with a matching s_tlast.
    d0 = done_cnt; t0 = tlast_cnt;
    run_frame(600, 600, 600, 0, 0, 0, 0, 0);
    idle(2);
    check("f600_done_once",  done_cnt - d0,  1);
    check("f600_tlast_once", tlast_cnt - t0, 1);
    check("f600_len_err",    len_err,        0);
    check("f600_beat_cnt",   beat_cnt,       600);

    // Backpressure fills the FIFO before the consumer wakes up.
    max_level = 0;
    run_frame(20, 20, 20, 0, 30, 0, 0, 0);
    idle(2);
    check("full_max_level", max_level, DEPTH);
    check("full_beat_cnt",  beat_cnt,  20);

    // Early s_tlast.
    t0 = tlast_cnt;
    run_frame(10, 7, 7, 0, 0, 0, 0, 0);
    idle(2);
    check("early_len_err",  len_err,        1);
    check("early_beat_cnt", beat_cnt,       7);
    check("early_tlast",    tlast_cnt - t0, 1);
    clr_err = 1; cycle(); clr_err = 0;
    check("early_cleared",  len_err,        0);

    // Missing s_tlast: the count closes the frame.
    t0 = tlast_cnt;
    run_frame(5, 5, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("forced_len_err", len_err,        1);
    check("forced_tlast",   tlast_cnt - t0, 1);
    clr_err = 1; cycle(); clr_err = 0;

    // Zero length start: error, stays idle.
    start = 1; cfg_len = 0; cycle(); start = 0;
    idle(3);
    check("zero_len_err",  len_err,  1);
    check("zero_s_tready", s_tready, 0);
    check("zero_beat_cnt", beat_cnt, 5);
    clr_err = 1; cycle(); clr_err = 0;
    check("zero_cleared",  len_err,  0);

    // Clear coinciding with an error event: the error wins.
    run_frame(4, 2, 2, 0, 0, 0, 0, 2);
    idle(2);
    check("set_beats_clr", len_err, 1);
    clr_err = 1; cycle(); clr_err = 0;

    // Random handshakes with a stray start mid-frame.
    max_level = 0; d0 = done_cnt;
    run_frame(600, 600, 600, 1, 0, 0, 250, 0);
    idle(2);
    check("rand_max_level", max_level <= DEPTH, 1);
    check("rand_done_once", done_cnt - d0,      1);
    check("rand_len_err",   len_err,            0);

    // Reset mid-frame, then a fresh frame.
    d0 = done_cnt;
    run_frame(600, 600, 600, 1, 0, 300, 0, 0);
    idle(5);
    check("rst_no_done", done_cnt - d0, 0);
    run_frame(8, 8, 8, 1, 0, 0, 0, 0);
    idle(2);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_cnt",  beat_cnt,      8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
